// File: rtl/dt_pack_writer.sv
// Thresholds a 128x128 8-bit result map and packs it MSB-first into 1024 16-bit STI words.
// Optional macro DT_PACK_BORDER_CLR_EN forces the outermost rows/columns to bit 0.
module dt_pack_writer #(
   parameter bit INVERT = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  thr,
   output logic        busy,
   output logic        done,
   output logic        res_rd,
   output logic [13:0] res_addr,
   input  logic [7:0]  res_di,
   output logic        sto_wr,
   output logic [9:0]  sto_addr,
   output logic [15:0] sto_do
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  thr_q, thr_d;
   logic        rd_q, rd_d;
   logic [13:0] addr_q, addr_d;
   logic        pend_q, pend_d;
   logic [13:0] cap_q, cap_d;
   logic [15:0] shift_q, shift_d;
   logic        wr_q, wr_d;
   logic [9:0]  waddr_q, waddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pix_bit_s;

   // Threshold decision for the pixel whose read data is on res_di this cycle (cap_q indexes it).
   always_comb begin
      pix_bit_s = INVERT ? (res_di < thr_q) : (res_di >= thr_q);
`ifdef DT_PACK_BORDER_CLR_EN
      if ((cap_q[13:7] == 7'd0) || (cap_q[13:7] == 7'd127) ||
          (cap_q[6:0] == 7'd0) || (cap_q[6:0] == 7'd127)) begin
         pix_bit_s = 1'b0;
      end else begin
         pix_bit_s = INVERT ? (res_di < thr_q) : (res_di >= thr_q);
      end
`endif
   end

   // Next-state, read issue, capture/pack and word-write logic.
   always_comb begin
      state_d = state_q;
      thr_d   = thr_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      pend_d  = rd_q;
      cap_d   = cap_q;
      shift_d = shift_q;
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = done_q;

      // res_di is only meaningful the cycle after a read; pend_q gates every capture.
      if (pend_q) begin
         shift_d = {shift_q[14:0], pix_bit_s};
         cap_d   = cap_q + 14'd1;
         if (cap_q[3:0] == 4'hF) begin
            wr_d    = 1'b1;
            waddr_d = cap_q[13:4];
            wdata_d = {shift_q[14:0], pix_bit_s};
         end else begin
            wr_d    = 1'b0;
         end
      end else begin
         shift_d = shift_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               thr_d   = thr;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               rd_d    = 1'b1;
               addr_d  = 14'd0;
               cap_d   = 14'd0;
               shift_d = 16'h0000;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            addr_d = addr_q + 14'd1;
            if (addr_q == 14'h3FFF) begin
               rd_d    = 1'b0;
               state_d = S_FLUSH;
            end else begin
               rd_d    = 1'b1;
            end
         end
         S_FLUSH: begin
            state_d = S_FIN;
         end
         S_FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            rd_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops every strobe immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         thr_q   <= 8'd0;
         rd_q    <= 1'b0;
         addr_q  <= 14'd0;
         pend_q  <= 1'b0;
         cap_q   <= 14'd0;
         shift_q <= 16'h0000;
         wr_q    <= 1'b0;
         waddr_q <= 10'd0;
         wdata_q <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         thr_q   <= thr_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         pend_q  <= pend_d;
         cap_q   <= cap_d;
         shift_q <= shift_d;
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign res_rd   = rd_q;
   assign res_addr = addr_q;
   assign sto_wr   = wr_q;
   assign sto_addr = waddr_q;
   assign sto_do   = wdata_q;

endmodule
